// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

   localparam int WORD_W = 32;

   // Fetch FSM states: waiting on memory, or parked with a buffered word.
   typedef enum logic [0:0] {
      IF_S_REQ  = 1'b0,
      IF_S_HOLD = 1'b1
   } if_state_t;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;

   // Clears the byte-offset bits so that every fetch address is a word address.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
      return {a[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Single-outstanding req/ack instruction-memory port.
interface if_fetch_if;
   import if_fetch_pkg::*;

   logic              req;
   logic [WORD_W-1:0] addr;
   logic              ack;
   logic [WORD_W-1:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_hold_buf.sv
// One-entry skid buffer that catches a fetch completing while ID is stalled.
module if_hold_buf
   import if_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [WORD_W-1:0] load_inst,
   input  logic [WORD_W-1:0] load_pc,
   input  logic              load_dly,
   output logic [WORD_W-1:0] inst,
   output logic [WORD_W-1:0] pc,
   output logic              dly,
   output logic              full
);

   // Occupancy flag: set on load, cleared on drain, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

   // Payload capture; contents are only meaningful while full is set.
   always_ff @(posedge clk) begin
      if (load) begin
         inst <= load_inst;
         pc   <= load_pc;
         dly  <= load_dly;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage plus IF/ID register with MIPS delay-slot redirects.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [WORD_W-1:0] branch_addr_i,
   input  logic              next_delay_i,
   if_fetch_if.master        imem,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] inst_o,
   output logic              in_delay_o,
   output logic              valid_o
);

   if_state_t         state;
   logic [WORD_W-1:0] pc_q;
   logic              pend_v;
   logic [WORD_W-1:0] pend_a;
   logic              dly_q;

   logic              free;
   logic              adv;
   logic              br_take;
   logic [WORD_W-1:0] tgt;
   logic [WORD_W-1:0] seq_pc;
   logic              dlv_dly;
   logic              hb_load;
   logic              hb_drain;
   logic              hb_full;
   logic [WORD_W-1:0] hb_inst;
   logic [WORD_W-1:0] hb_pc;
   logic              hb_dly;

   // Request is a pure function of state so the address stays put until ack.
   assign imem.req  = (state == IF_S_REQ) && !rst;
   assign imem.addr = pc_q;

   // Handshake decode: output-register availability, ID advance and redirect.
   always_comb begin
      free     = !valid_o || !stall_i;
      adv      = valid_o && !stall_i;
      br_take  = adv && branch_flag_i;
      tgt      = word_align(branch_addr_i);
      seq_pc   = pend_v ? pend_a : pc_q + PC_STEP;
      // A delivery coinciding with an ID advance is the word that follows the
      // advancing instruction, so its delay flag comes straight from decode.
      dlv_dly  = adv ? next_delay_i : dly_q;
      hb_load  = (state == IF_S_REQ) && imem.ack && !free && !rst;
      hb_drain = (state == IF_S_HOLD) && !stall_i && hb_full && !rst;
   end

   if_hold_buf u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (hb_load),
      .drain     (hb_drain),
      .load_inst (imem.rdata),
      .load_pc   (pc_q),
      .load_dly  (dly_q),
      .inst      (hb_inst),
      .pc        (hb_pc),
      .dly       (hb_dly),
      .full      (hb_full)
   );

   // Fetch FSM, PC/redirect bookkeeping and the IF/ID output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IF_S_REQ;
         pc_q       <= RESET_PC;
         pend_v     <= 1'b0;
         dly_q      <= 1'b0;
         valid_o    <= 1'b0;
         inst_o     <= NOP_WORD;
         pc_o       <= '0;
         in_delay_o <= 1'b0;
      end else begin
         if (adv) begin
            dly_q <= next_delay_i;
         end
         case (state)
            IF_S_REQ: begin
               if (imem.ack) begin
                  // A redirect accepted now makes this word the delay slot.
                  pc_q   <= br_take ? tgt : seq_pc;
                  pend_v <= 1'b0;
                  dly_q  <= 1'b0;
                  if (free) begin
                     valid_o    <= 1'b1;
                     inst_o     <= imem.rdata;
                     pc_o       <= pc_q;
                     in_delay_o <= dlv_dly;
                  end else begin
                     state <= IF_S_HOLD;
                  end
               end else begin
                  // Delay slot still in flight: apply the target after it.
                  if (br_take) begin
                     pend_v <= 1'b1;
                     pend_a <= tgt;
                  end
                  if (free) begin
                     valid_o    <= 1'b0;
                     inst_o     <= NOP_WORD;
                     in_delay_o <= 1'b0;
                  end
               end
            end
            IF_S_HOLD: begin
               if (!stall_i && hb_full) begin
                  // The stalled instruction's delay-slot verdict is only final
                  // at its advance, which is this very cycle.
                  valid_o    <= 1'b1;
                  inst_o     <= hb_inst;
                  pc_o       <= hb_pc;
                  in_delay_o <= hb_dly || next_delay_i;
                  dly_q      <= 1'b0;
                  state      <= IF_S_REQ;
                  if (br_take) begin
                     pc_q <= tgt;
                  end
               end
            end
            default: state <= IF_S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table, directed corner cases and a
// randomized run against an instruction-stream reference model.
module tb_if_fetch;
   import if_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_addr_i;
   logic        next_delay_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        in_delay_o;
   logic        valid_o;

   if_fetch_if imem_bus ();

   if_fetch #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .next_delay_i  (next_delay_i),
      .imem          (imem_bus),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .in_delay_o    (in_delay_o),
      .valid_o       (valid_o)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          fix_lat = 0;
   bit          rand_lat = 0;
   int          wcnt = 0;
   int          cur_lat = 0;
   logic [31:0] held_addr = '0;
   logic        obs_req;
   logic [31:0] obs_addr;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Memory model: answers a request after a chosen number of wait cycles.
   task automatic mem_respond();
      obs_req  = imem_bus.req;
      obs_addr = imem_bus.addr;
      if (imem_bus.req && !rst) begin
         check("addr_align", {30'd0, imem_bus.addr[1:0]}, 32'd0);
         if (wcnt == 0) begin
            held_addr = imem_bus.addr;
            cur_lat   = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
         end else begin
            check("addr_stable", imem_bus.addr, held_addr);
         end
         if (wcnt >= cur_lat) begin
            imem_bus.ack   = 1'b1;
            imem_bus.rdata = imem_bus.addr ^ XOR_K;
            wcnt = 0;
         end else begin
            imem_bus.ack   = 1'b0;
            imem_bus.rdata = 32'h0BAD_0BAD;
            wcnt++;
         end
      end else begin
         imem_bus.ack   = 1'b0;
         imem_bus.rdata = 32'h0BAD_0BAD;
         if (rst) wcnt = 0;
      end
   endtask

   // One clock: inputs already set by the caller, outputs sampled 1 after edge.
   task automatic tick();
      #1;
      mem_respond();
      @(posedge clk);
      #1;
   endtask

   task automatic dec_idle();
      branch_flag_i = 1'b0;
      branch_addr_i = 32'h0;
      next_delay_i  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      stall_i = 1'b0;
      dec_idle();
      for (int i = 0; i < n; i++) tick();
      check("reset_valid", {31'd0, valid_o}, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run_to_pc(input logic [31:0] pc, output bit ok);
      ok = 0;
      stall_i = 1'b0;
      dec_idle();
      for (int i = 0; i < 200; i++) begin
         tick();
         if (valid_o && pc_o == pc) begin
            ok = 1;
            break;
         end
      end
      check("run_to_pc_reached", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_delivery(input string name, input logic [31:0] want_pc, input logic want_dly);
      bit got;
      got = 0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (valid_o) begin
            got = 1;
            break;
         end
      end
      check({name, "_seen"}, {31'd0, got}, 32'd1);
      if (got) begin
         check({name, "_pc"}, pc_o, want_pc);
         check({name, "_dly"}, {31'd0, in_delay_o}, {31'd0, want_dly});
         check({name, "_inst"}, inst_o, want_pc ^ XOR_K);
      end
   endtask

   // Reference model: expected program-order stream with delay-slot redirects.
   task automatic random_phase(input int ncycles);
      logic [31:0] exp_pc, saved_tgt, id_tgt, hold_pc, hold_inst;
      logic        exp_dly, hold_dly;
      bit          id_br, prev_valid, prev_adv;
      int          ndeliv;
      rand_lat = 1;
      do_reset(2);
      exp_pc = RST_PC; exp_dly = 0; saved_tgt = '0; id_tgt = '0;
      id_br = 0; prev_valid = 0; prev_adv = 0; ndeliv = 0;
      hold_pc = '0; hold_inst = '0; hold_dly = 0;
      for (int c = 0; c < ncycles; c++) begin
         stall_i       = ($urandom_range(0, 3) == 0);
         branch_flag_i = valid_o && id_br;
         next_delay_i  = valid_o && id_br;
         branch_addr_i = id_tgt;
         prev_valid    = valid_o;
         prev_adv      = valid_o && !stall_i;
         tick();
         if (valid_o && (!prev_valid || prev_adv)) begin
            ndeliv++;
            check("rnd_pc", pc_o, exp_pc);
            check("rnd_dly", {31'd0, in_delay_o}, {31'd0, exp_dly});
            check("rnd_inst", inst_o, exp_pc ^ XOR_K);
            if (exp_dly) begin
               exp_pc  = saved_tgt;
               exp_dly = 0;
               id_br   = 0;
            end else begin
               id_br = ($urandom_range(0, 3) == 0);
               case ($urandom_range(0, 5))
                  0:       id_tgt = 32'h0000_0100;
                  1:       id_tgt = 32'h0000_0203;
                  2:       id_tgt = 32'hFFFF_FFF9;
                  3:       id_tgt = exp_pc;
                  4:       id_tgt = exp_pc + 32'd4;
                  default: id_tgt = $urandom & 32'h0000_0FFF;
               endcase
               saved_tgt = {id_tgt[31:2], 2'b00};
               exp_pc    = exp_pc + 32'd4;
               exp_dly   = id_br;
            end
            hold_pc = pc_o; hold_inst = inst_o; hold_dly = in_delay_o;
         end else if (valid_o) begin
            check("rnd_hold_pc", pc_o, hold_pc);
            check("rnd_hold_inst", inst_o, hold_inst);
            check("rnd_hold_dly", {31'd0, in_delay_o}, {31'd0, hold_dly});
         end else begin
            check("rnd_bubble_inst", inst_o, 32'h0);
         end
      end
      check("rnd_progress", {31'd0, ndeliv > 100}, 32'd1);
      rand_lat = 0;
      stall_i = 1'b0;
      dec_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      rst = 1'b1;
      stall_i = 1'b0;
      dec_idle();
      imem_bus.ack = 1'b0;
      imem_bus.rdata = 32'h0;

      // Reset, zero-wait sequential fetch, then a 4-cycle stall over the hold buffer.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h00, 32'hA5A5_0000};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h04, 32'hA5A5_0004};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 32'hA5A5_0008};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0C, 32'hA5A5_000C};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'hA5A5_0010};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'hA5A5_0010};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'hA5A5_0010};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'hA5A5_0010};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 32'hA5A5_0010};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h14, 32'hA5A5_0014};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h18, 32'hA5A5_0018};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h1C, 32'hA5A5_001C};

      fix_lat = 0;
      for (int i = 0; i < 14; i++) begin
         rst     = vecs[i].rst;
         stall_i = vecs[i].stall;
         tick();
         check($sformatf("vec%0d_req", i), {31'd0, obs_req}, {31'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), obs_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
         check($sformatf("vec%0d_inst", i), inst_o, vecs[i].exp_inst);
         check($sformatf("vec%0d_dly", i), {31'd0, in_delay_o}, 32'd0);
      end

      // Slow memory: three wait cycles, bubbles between deliveries.
      fix_lat = 3;
      do_reset(1);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            tick();
            check("slow_addr", obs_addr, 32'(4 * k));
            if (j < 3) begin
               check("slow_bubble_valid", {31'd0, valid_o}, 32'd0);
               check("slow_bubble_inst", inst_o, 32'h0);
            end else begin
               check("slow_valid", {31'd0, valid_o}, 32'd1);
               check("slow_pc", pc_o, 32'(4 * k));
            end
         end
      end

      // Taken branch at 0x20 while the delay-slot fetch is outstanding.
      fix_lat = 2;
      do_reset(1);
      run_to_pc(32'h20, ok);
      if (ok) begin
         branch_flag_i = 1'b1; branch_addr_i = 32'h100; next_delay_i = 1'b1;
         tick();
         dec_idle();
         wait_delivery("br_slot", 32'h24, 1'b1);
         wait_delivery("br_tgt", 32'h100, 1'b0);
         wait_delivery("br_after", 32'h104, 1'b0);
      end

      // Zero-wait memory: branch accepted in the cycle the delay slot acks.
      fix_lat = 0;
      do_reset(1);
      run_to_pc(32'h20, ok);
      if (ok) begin
         branch_flag_i = 1'b1; branch_addr_i = 32'h203; next_delay_i = 1'b1;
         tick();
         dec_idle();
         check("zw_slot_addr", obs_addr, 32'h24);
         check("zw_slot_pc", pc_o, 32'h24);
         check("zw_slot_dly", {31'd0, in_delay_o}, 32'd1);
         tick();
         check("zw_tgt_addr", obs_addr, 32'h200);
         check("zw_tgt_pc", pc_o, 32'h200);
         check("zw_tgt_dly", {31'd0, in_delay_o}, 32'd0);
         tick();
         check("zw_next_addr", obs_addr, 32'h204);
      end

      // Reset during an outstanding fetch at 0x40 with a redirect pending.
      fix_lat = 3;
      do_reset(1);
      run_to_pc(32'h3C, ok);
      if (ok) begin
         branch_flag_i = 1'b1; branch_addr_i = 32'h300; next_delay_i = 1'b1;
         tick();
         dec_idle();
         check("rst_mid_req", {31'd0, obs_req}, 32'd1);
         check("rst_mid_addr", obs_addr, 32'h40);
         rst = 1'b1;
         tick();
         check("rst_mid_req_low", {31'd0, obs_req}, 32'd0);
         check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
         check("rst_mid_inst", inst_o, 32'h0);
         rst = 1'b0;
         tick();
         check("rst_first_req", {31'd0, obs_req}, 32'd1);
         check("rst_first_addr", obs_addr, RST_PC);
         wait_delivery("rst_d0", RST_PC, 1'b0);
         wait_delivery("rst_d1", RST_PC + 32'd4, 1'b0);
      end

      random_phase(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
